// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter: pops one word per frame and shifts it out LSB-first.
// Optional even-parity bit between data and stop is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int BAUD_DIV = 651
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [DBIT-1:0] shreg;
  logic [3:0]      s;
  logic [NW-1:0]   n;
  logic [DW-1:0]   div;
  logic            tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            par;
`endif

  // rd, tx_busy and tx_done must be valid in the very cycle the condition arises,
  // so they are decoded from registered state rather than registered themselves.
  assign tick    = (state != IDLE) && (div == DW'(BAUD_DIV - 1));
  assign rd      = reset && (state == IDLE) && !empty;
  assign tx_busy = (state != IDLE) || rd;
  assign tx_done = (state == STOP) && tick && (s == 4'(SB_TICK - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      shreg <= '0;
      s     <= '0;
      n     <= '0;
      div   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      if (state != IDLE) begin
        div <= tick ? '0 : div + DW'(1);
      end
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shreg <= r_data;
`ifdef FIFO_UART_TX_PARITY_EN
            par   <= ^r_data;
`endif
            s     <= '0;
            n     <= '0;
            div   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s == 4'd15) begin
              s     <= '0;
              tx    <= shreg[0];
              state <= DATA;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              s     <= '0;
              shreg <= {1'b0, shreg[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                tx    <= par;
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                n  <= n + NW'(1);
                tx <= shreg[1];
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == 4'd15) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= IDLE;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: queue-based FIFO model plus expected-waveform frame checker.
module tb_fifo_uart_tx;

  localparam int D   = 4;
  localparam int BIT = 16 * D;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NSEG = 11;
`else
  localparam int NSEG = 10;
`endif
  localparam int L = NSEG * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd, tx, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] junk = 8'h00;
  int         rd_count = 0;
  int         pop_while_empty = 0;
  logic       pop_now;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(D)) dut (
    .clk(clk), .reset(reset), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // FIFO read port: pop on an rd seen at the edge, then present the new head.
  always @(posedge clk) begin
    pop_now = rd;
    #1;
    if (pop_now === 1'b1) begin
      rd_count++;
      if (fifo_q.size() == 0) pop_while_empty++;
      else void'(fifo_q.pop_front());
    end
    empty  = (fifo_q.size() == 0);
    r_data = empty ? junk : fifo_q[0];
  end

  task automatic wait_pop(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_pop_timeout: rd not seen within 3000 cycles, required a pop", tag);
    end
  endtask

  // Called at the negedge of the pop cycle; follows the whole frame.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic       exp_bits[NSEG];
    int         bad[NSEG];
    int         done_at = -1, done_cnt = 0, busy_bad = 0, rd_in_frame = 0;
    logic [7:0] dec = 8'h00;
    int         seg;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits[9] = ^b;
`endif
    exp_bits[NSEG-1] = 1'b1;
    for (int i = 0; i < NSEG; i++) bad[i] = 0;

    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_pop_cycle: tx=%b tx_busy=%b, required tx=1 tx_busy=1", tag, tx, tx_busy);
    end
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      seg = (k - 1) / BIT;
      if (tx !== exp_bits[seg]) bad[seg]++;
      if (tx_done === 1'b1) begin done_cnt++; done_at = k; end
      if (tx_busy !== 1'b1) busy_bad++;
      if (rd === 1'b1) rd_in_frame++;
      if (seg >= 1 && seg <= 8 && ((k - 1) % BIT) == BIT / 2) dec[seg-1] = tx;
    end
    for (int i = 0; i < NSEG; i++) begin
      checks++;
      if (bad[i] != 0) begin
        errors++;
        $display("FAIL %s_seg%0d: %0d cycles of tx differ, required tx=%b for all %0d", tag, i, bad[i], exp_bits[i], BIT);
      end
    end
    checks++;
    if (dec !== b) begin
      errors++;
      $display("FAIL %s_decoded: got 0x%02h required 0x%02h", tag, dec, b);
    end
    checks++;
    if (done_cnt != 1 || done_at != L) begin
      errors++;
      $display("FAIL %s_tx_done: %0d pulses, last at clock %0d, required 1 pulse at %0d", tag, done_cnt, done_at, L);
    end
    checks++;
    if (busy_bad != 0 || rd_in_frame != 0) begin
      errors++;
      $display("FAIL %s_busy_rd: busy low %0d cycles, rd %0d cycles, required 0 and 0", tag, busy_bad, rd_in_frame);
    end
  endtask

  task automatic test_reset();
    int bad = 0, rd_seen = 0, tx_low = 0;
    reset = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_outputs: %0d bad cycles, required tx=1 rd=0 tx_busy=0 tx_done=0", bad);
    end
    reset = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd !== 1'b0) rd_seen++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) tx_low++;
    end
    checks++;
    if (rd_seen != 0) begin
      errors++;
      $display("FAIL idle_no_rd: rd high %0d cycles, required 0", rd_seen);
    end
    checks++;
    if (tx_low != 0) begin
      errors++;
      $display("FAIL idle_tx_high: %0d cycles tx low or busy, required 0", tx_low);
    end
  endtask

  task automatic test_single();
    bit ok;
    fifo_q.push_back(8'h55);
    wait_pop("single", ok);
    if (ok) check_frame(8'h55, "single");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rd0 = rd_count;
    fifo_q.push_back(8'h03);
    fifo_q.push_back(8'h05);
    wait_pop("b2b", ok);
    if (ok) begin
      check_frame(8'h03, "b2b_first");
      @(negedge clk);
      checks++;
      if (rd !== 1'b1 || tx !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap: rd=%b tx=%b in cycle after tx_done, required rd=1 tx=1", rd, tx);
      end else begin
        check_frame(8'h05, "b2b_second");
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rd_count - rd0 != 2) begin
      errors++;
      $display("FAIL b2b_rd_count: got %0d pops, required 2", rd_count - rd0);
    end
  endtask

  task automatic test_rdata_hold();
    bit ok;
    junk = 8'hFF;
    fifo_q.push_back(8'hA5);
    wait_pop("hold", ok);
    if (ok) check_frame(8'hA5, "hold");
    junk = 8'h00;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int stray = 0;
    logic [7:0] b;
    fifo_q.push_back(8'hF0);
    wait_pop("midrst", ok);
    if (ok) begin
      repeat (4 * BIT + 20) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
        errors++;
        $display("FAIL midrst_bit3: tx=%b during bit 3 of 0xF0, required 0", tx);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after: tx=%b tx_done=%b tx_busy=%b, required 1 0 0", tx, tx_done, tx_busy);
      end
      reset = 1'b1;
      for (int i = 0; i < 800; i++) begin
        @(negedge clk);
        if (tx_done !== 1'b0 || tx !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
        errors++;
        $display("FAIL midrst_quiet: %0d cycles with tx_done or tx low, required 0", stray);
      end
      b = 8'($urandom);
      fifo_q.push_back(b);
      wait_pop("midrst_next", ok);
      if (ok) check_frame(b, "midrst_next");
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] b;
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      fifo_q.push_back(b);
      wait_pop("random", ok);
      if (ok) check_frame(b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rdata_hold();
    test_reset_mid();
    test_random();
    repeat (10) @(negedge clk);
    checks++;
    if (pop_while_empty != 0) begin
      errors++;
      $display("FAIL rd_while_empty: got %0d pops while empty, required 0", pop_while_empty);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drains bytes from the receive/loopback FIFO and serializes them as 8N1 UART frames on `tx`. It is the reading end of the FIFO: it watches `empty`, pops one word with a single-cycle `rd` pulse, and transmits it LSB-first at a baud rate derived from the 100 MHz board clock. It sits between the FIFO's read port and the board's TX pin.

## Interface
- `DBIT`, 8, data bits per frame.
- `SB_TICK`, 16, stop-bit length in oversampling ticks (16 = 1 stop bit).
- `BAUD_DIV`, 651, clocks per 16x oversampling tick (100 MHz / (9600·16)).
- `clk`  in  1  system clock, 100 MHz, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `empty`  in  1  FIFO empty flag.
- `r_data`  in  DBIT  FIFO head word; valid whenever `empty`=0, advances after a `rd` pulse.
- `rd`  out  1  FIFO pop strobe, one cycle wide.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high from the pop cycle until the frame's last stop tick.
- `tx_done`  out  1  one-cycle pulse at end of each frame.

## Operation
- States: IDLE, START, DATA, STOP (plus PARITY when configured).
- IDLE: `tx`=1. If `empty`=0: assert `rd` this cycle, load `r_data` into shift register, clear tick counter, bit counter and baud divider, go START. If `empty`=1: stay, `rd`=0.
- Baud divider: counts 0..BAUD_DIV-1 outside IDLE; `tick` true in the cycle it equals BAUD_DIV-1, then wraps to 0.
- Tick counter `s` (4 bits): increments on each tick; state advances on the tick where the per-bit count completes.
- START: `tx`=0 for 16 ticks, then DATA with `n`=0.
- DATA: `tx`=shift[0]; after 16 ticks shift right, `n`++; after bit `n`=DBIT-1 go STOP (or PARITY).
- STOP: `tx`=1 for SB_TICK ticks; on the final tick pulse `tx_done`, go IDLE.
- `rd` asserts at most once per frame and never while `empty`=1.
- `r_data` sampled only in the pop cycle; later changes to `r_data` do not affect the frame in flight.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE, `tx`=1, `rd`=0, `tx_busy`=0, `tx_done`=0, all counters 0. Takes priority over every other event.
- Reset mid-frame: `tx` returns high on the next edge; the byte is lost (already popped); no `tx_done`.
- Pop latency: `rd` high in the first cycle IDLE sees `empty`=0; `tx` falls on the next edge.
- Bit duration: exactly 16·BAUD_DIV clocks; stop duration SB_TICK·BAUD_DIV clocks.
- Frame (no parity): (1+DBIT)·16·BAUD_DIV + SB_TICK·BAUD_DIV clocks from the `tx` falling edge to the `tx_done` cycle inclusive.
- Back-to-back: after `tx_done`, one IDLE cycle with `tx`=1; if `empty`=0, `rd` pulses in that cycle, so frames are separated by one clock of extra idle.
- `empty` rising during a frame has no effect; it is only sampled in IDLE.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined: PARITY state between DATA and STOP; `tx` = XOR of the DBIT data bits (even parity) for 16 ticks; frame grows by 16·BAUD_DIV clocks.
- Undefined: no PARITY state, 8N1 frame only.

## Test plan
(All with BAUD_DIV=4, so 64 clocks per bit.)
- Hold `reset`=0 three cycles, `empty`=1 -> `tx`=1, `rd`=0, `tx_busy`=0 throughout; no `rd` for 1000 cycles while `empty` stays 1.
- FIFO holds 0x55, drop `empty` -> one `rd` pulse; `tx` low 64 clks; then 1,0,1,0,1,0,1,0 at 64 clks each; high 64 clks; `tx_done` at clock 640 after the `tx` fall.
- FIFO holds 0x03 then 0x05 -> two frames, exactly two `rd` pulses; second `rd` in the cycle after the first `tx_done`; decoded bytes 0x03, 0x05.
- Change `r_data` from 0xA5 to 0xFF after the pop cycle of 0xA5 -> serialized byte is 0xA5.
- Assert `reset`=0 during bit 3 of 0xF0 -> `tx`=1 next edge; no `tx_done`; next non-empty pop starts a clean frame.
- With `FIFO_UART_TX_PARITY_EN`, send 0x07 -> parity bit 1 after bit 7; `tx_done` at 704 clocks.
